// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush scheduler.
package pipe_ctrl_pkg;

  localparam int MC_LAT_DIV = 33;
  localparam int MC_CNT_W   = 8;

  typedef enum logic {
    RUN     = 1'b0,
    MC_WAIT = 1'b1
  } mc_state_t;

  typedef struct packed {
    logic stall;
    logic flush;
  } stage_ctrl_t;

endpackage

// File: rtl/pipe_ctrl_mc_timer.sv
// Multi-cycle op countdown: load MC_LAT-1, decrement on enable, flag zero.
module mc_timer
  import pipe_ctrl_pkg::*;
#(
  parameter int MC_LAT = MC_LAT_DIV
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic dec,
  output logic done
);

  logic [MC_CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)
      cnt_d = MC_CNT_W'(MC_LAT - 1);
    else if (dec && cnt_q != '0)
      cnt_d = cnt_q - MC_CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign done = (cnt_q == '0);

endmodule

// File: rtl/pipe_ctrl.sv
// Five-stage stall/flush scheduler with multi-cycle wait and wrong-path discard.
// Optional perf counters are built when PIPE_CTRL_PERF_EN is defined.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MC_LAT = MC_LAT_DIV
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        bubble_d,
  input  logic        ireq_busy,
  input  logic        dreq_busy,
  input  logic        redirect_e,
  input  logic        mc_start,
  output logic        stall_f,
  output logic        stall_d,
  output logic        stall_e,
  output logic        stall_m,
  output logic        flush_d,
  output logic        flush_e,
  output logic        flush_m,
  output logic        flush_w,
  output logic        fetch_discard,
  output logic        mc_busy,
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_flush_cnt
);

  mc_state_t   state_q, state_d;
  logic        discard_q, discard_d;
  logic        mc_done, mc_hold, mc_launch, mc_dec;
  logic        redir_acc, fetch_wait;
  stage_ctrl_t ctl_f, ctl_d, ctl_e, ctl_m, ctl_w;

  assign mc_hold    = (state_q == MC_WAIT) && !mc_done;
  assign mc_launch  = mc_start && !dreq_busy && !mc_hold;
  assign mc_dec     = (state_q == MC_WAIT) && !dreq_busy;
  assign redir_acc  = redirect_e && !dreq_busy
                    && !mc_hold && !mc_launch;
  assign fetch_wait = ireq_busy || discard_q;

  mc_timer #(.MC_LAT(MC_LAT)) u_timer (
    .clk   (clk),
    .reset (reset),
    .load  (mc_launch),
    .dec   (mc_dec),
    .done  (mc_done)
  );

  always_comb begin
    state_d   = state_q;
    discard_d = discard_q;
    if (mc_launch)
      state_d = MC_WAIT;
    else if (state_q == MC_WAIT && mc_done)
      state_d = RUN;
    if (redir_acc && fetch_wait)
      discard_d = 1'b1;
    else if (!ireq_busy)
      discard_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= RUN;
      discard_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      discard_q <= discard_d;
    end
  end

  // The launch cycle holds E like MC_WAIT but leaves M alone.
  always_comb begin
    ctl_f = '0;
    ctl_d = '0;
    ctl_e = '0;
    ctl_m = '0;
    ctl_w = '0;
    if (reset) begin
      ctl_d.flush = 1'b1;
      ctl_e.flush = 1'b1;
      ctl_m.flush = 1'b1;
      ctl_w.flush = 1'b1;
    end else if (dreq_busy) begin
      ctl_f.stall = 1'b1;
      ctl_d.stall = 1'b1;
      ctl_e.stall = 1'b1;
      ctl_m.stall = 1'b1;
      ctl_w.flush = 1'b1;
    end else if (mc_hold || mc_launch) begin
      ctl_f.stall = 1'b1;
      ctl_d.stall = 1'b1;
      ctl_e.stall = 1'b1;
      ctl_m.flush = mc_hold;
    end else begin
      if (redir_acc) begin
        ctl_d.flush = 1'b1;
        ctl_e.flush = 1'b1;
      end else if (bubble_d) begin
        ctl_d.stall = 1'b1;
        ctl_e.flush = 1'b1;
      end else if (fetch_wait) begin
        ctl_d.flush = 1'b1;
      end
      ctl_f.stall = (bubble_d && !redir_acc) || fetch_wait;
    end
  end

  assign stall_f       = ctl_f.stall;
  assign stall_d       = ctl_d.stall;
  assign stall_e       = ctl_e.stall;
  assign stall_m       = ctl_m.stall;
  assign flush_d       = ctl_d.flush;
  assign flush_e       = ctl_e.flush;
  assign flush_m       = ctl_m.flush;
  assign flush_w       = ctl_w.flush;
  assign fetch_discard = !reset && discard_q && !ireq_busy;
  assign mc_busy       = (state_q == MC_WAIT);

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] perf_stall_q, perf_stall_d;
  logic [31:0] perf_flush_q, perf_flush_d;

  always_comb begin
    perf_stall_d = perf_stall_q;
    perf_flush_d = perf_flush_q;
    if (stall_f && perf_stall_q != '1)
      perf_stall_d = perf_stall_q + 32'd1;
    if ((flush_d || flush_e) && perf_flush_q != '1)
      perf_flush_d = perf_flush_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else begin
      perf_stall_q <= perf_stall_d;
      perf_flush_q <= perf_flush_d;
    end
  end

  assign perf_stall_cnt = perf_stall_q;
  assign perf_flush_cnt = perf_flush_q;
`else
  assign perf_stall_cnt = '0;
  assign perf_flush_cnt = '0;
`endif

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(redirect_e && mc_start))
        else $error("redirect_e and mc_start together");
      assert (!ctl_f.flush && !ctl_w.stall)
        else $error("F flush or W stall requested");
    end
  end
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl against a rule-table reference model.
module tb_pipe_ctrl;

  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        reset, bubble_d, ireq_busy, dreq_busy;
  logic        redirect_e, mc_start;
  logic        stall_f, stall_d, stall_e, stall_m;
  logic        flush_d, flush_e, flush_m, flush_w;
  logic        fetch_discard, mc_busy;
  logic [31:0] perf_stall_cnt, perf_flush_cnt;

  always #5 clk = ~clk;

  pipe_ctrl #(.MC_LAT(LAT)) dut (
    .clk            (clk),
    .reset          (reset),
    .bubble_d       (bubble_d),
    .ireq_busy      (ireq_busy),
    .dreq_busy      (dreq_busy),
    .redirect_e     (redirect_e),
    .mc_start       (mc_start),
    .stall_f        (stall_f),
    .stall_d        (stall_d),
    .stall_e        (stall_e),
    .stall_m        (stall_m),
    .flush_d        (flush_d),
    .flush_e        (flush_e),
    .flush_m        (flush_m),
    .flush_w        (flush_w),
    .fetch_discard  (fetch_discard),
    .mc_busy        (mc_busy),
    .perf_stall_cnt (perf_stall_cnt),
    .perf_flush_cnt (perf_flush_cnt)
  );

  int errors = 0;
  int checks = 0;

  // Model state: E-hold cycles left, final-cycle flag, discard flag, perf.
  int          m_hold = 0;
  logic        m_tail = 1'b0;
  logic        m_disc = 1'b0;
  logic [31:0] m_ps = '0;
  logic [31:0] m_pf = '0;
  logic [9:0]  last_g;

  // Stage bit order: 0=F 1=D 2=E 3=M 4=W.
  function automatic void apply(input logic on,
                                input logic [4:0] dec,
                                input logic [4:0] sm,
                                input logic [4:0] fm,
                                inout logic [4:0] dn,
                                inout logic [4:0] st,
                                inout logic [4:0] fl);
    logic [4:0] take;
    take = dec & ~dn & {5{on}};
    st |= take & sm;
    fl |= take & fm;
    dn |= take;
  endfunction

  function automatic logic [9:0] model_out();
    logic [4:0] dn, st, fl;
    logic r1, r2, r3, launch, hold, fd, busy;
    dn = '0; st = '0; fl = '0;
    hold   = (m_hold > 0);
    launch = mc_start && !dreq_busy && !hold;
    r1 = dreq_busy;
    r2 = hold || launch;
    r3 = redirect_e && !r1 && !r2;
    apply(r1, 5'b11111, 5'b01111, 5'b10000, dn, st, fl);
    apply(r2, 5'b01111, 5'b00111, {1'b0, hold, 3'b000}, dn, st, fl);
    apply(r3, 5'b00110, 5'b00000, 5'b00110, dn, st, fl);
    apply(bubble_d && !r3, 5'b00111, 5'b00011, 5'b00100, dn, st, fl);
    apply(ireq_busy || m_disc, 5'b00011, 5'b00001, 5'b00010, dn, st, fl);
    fd = m_disc && !ireq_busy;
    if (reset) begin
      st = '0;
      fl = 5'b11110;
      fd = 1'b0;
    end
    busy = hold || m_tail;
    return {st[0], st[1], st[2], st[3],
            fl[1], fl[2], fl[3], fl[4], fd, busy};
  endfunction

  task automatic model_update(input logic [9:0] e);
    logic hold, launch, r3;
    hold   = (m_hold > 0);
    launch = mc_start && !dreq_busy && !hold;
    r3     = redirect_e && !dreq_busy && !hold && !launch;
    if (reset) begin
      m_hold = 0;
      m_tail = 1'b0;
      m_disc = 1'b0;
      m_ps   = '0;
      m_pf   = '0;
    end else begin
      if (r3 && (ireq_busy || m_disc)) m_disc = 1'b1;
      else if (!ireq_busy)             m_disc = 1'b0;
      if (launch) begin
        m_hold = LAT - 1;
        m_tail = 1'b0;
      end else if (hold) begin
        if (!dreq_busy) begin
          m_hold--;
          if (m_hold == 0) m_tail = 1'b1;
        end
      end else begin
        m_tail = 1'b0;
      end
      if (e[9] && m_ps != 32'hFFFF_FFFF) m_ps++;
      if ((e[5] || e[4]) && m_pf != 32'hFFFF_FFFF) m_pf++;
    end
  endtask

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic step(input string tag);
    logic [9:0]  e, g;
    logic [63:0] pe, pg;
    @(negedge clk);
    e = model_out();
    g = {stall_f, stall_d, stall_e, stall_m,
         flush_d, flush_e, flush_m, flush_w,
         fetch_discard, mc_busy};
    last_g = g;
    checks++;
    assert (g === e) else begin
      errors++;
      $error("FAIL %s: got %b exp %b", tag, g, e);
    end
`ifdef PIPE_CTRL_PERF_EN
    pe = {m_ps, m_pf};
`else
    pe = '0;
`endif
    pg = {perf_stall_cnt, perf_flush_cnt};
    checks++;
    assert (pg === pe) else begin
      errors++;
      $error("FAIL %s_perf: got %h exp %h", tag, pg, pe);
    end
    @(posedge clk);
    model_update(e);
    #1;
  endtask

  task automatic set_in(input logic r, input logic b, input logic ib,
                        input logic db, input logic re, input logic ms);
    reset      = r;
    bubble_d   = b;
    ireq_busy  = ib;
    dreq_busy  = db;
    redirect_e = re;
    mc_start   = ms;
  endtask

  initial begin
    int n0, n1;
    logic r, ms, re;

    set_in(1, 1, 1, 1, 1, 1);
    step("rst0");
    chk("rst_flush_d", int'(flush_d), 1);
    step("rst1");
    chk("rst_stall_f", int'(stall_f), 0);
    set_in(0, 0, 0, 0, 0, 0);
    step("idle");
    chk("post_rst_busy", int'(last_g[0]), 0);
    chk("post_rst_fd", int'(last_g[1]), 0);

    set_in(0, 1, 0, 0, 0, 0);
    step("bubble");
    chk("bubble_sfd_fe", int'({last_g[9], last_g[8], last_g[4]}), 7);
    set_in(0, 0, 0, 0, 0, 0);
    step("bubble_after");
    chk("bubble_after_all0", int'(last_g), 0);

    n0 = 0; n1 = 0;
    set_in(0, 0, 0, 0, 0, 1);
    step("mc0");
    n0 += last_g[7]; n1 += last_g[3];
    set_in(0, 0, 0, 0, 0, 0);
    for (int i = 1; i < 6; i++) begin
      step("mc");
      n0 += last_g[7]; n1 += last_g[3];
    end
    chk("mc_stall_e_cycles", n0, LAT);
    chk("mc_flush_m_cycles", n1, LAT - 1);

    n0 = 0;
    for (int i = 0; i < 9; i++) begin
      set_in(0, 0, 0, (i == 2 || i == 3), 0, (i == 0));
      step("mc_dreq");
      n0 += last_g[7];
    end
    chk("mc_dreq_stall_e_cycles", n0, LAT + 2);

    n0 = 0; n1 = 0;
    set_in(0, 0, 1, 0, 1, 0);
    step("redir0");
    chk("redir_flush_de", int'({last_g[5], last_g[4]}), 3);
    n0 += last_g[9]; n1 += last_g[1];
    set_in(0, 0, 1, 0, 0, 0);
    for (int i = 1; i < 5; i++) begin
      if (i == 3) ireq_busy = 1'b0;
      step("redir");
      if (i < 4) n0 += last_g[9];
      n1 += last_g[1];
    end
    chk("redir_stall_f_cycles", n0, 4);
    chk("redir_discard_pulses", n1, 1);

    n0 = 0;
    for (int i = 0; i < 3; i++) begin
      set_in(0, 0, 0, (i < 2), 1, 0);
      step("redir_dreq");
      if (i < 2) n0 += last_g[5] | last_g[4];
    end
    chk("redir_dreq_no_flush", n0, 0);
    chk("redir_dreq_late_flush", int'({last_g[5], last_g[4]}), 3);

    set_in(0, 0, 0, 0, 0, 0);
    step("pre_rand");
    for (int i = 0; i < 3000; i++) begin
      r  = ($urandom_range(0, 79) == 0);
      ms = (m_hold == 0) && ($urandom_range(0, 11) == 0);
      re = !ms && ($urandom_range(0, 6) == 0);
      set_in(r,
             ($urandom_range(0, 3) == 0),
             ($urandom_range(0, 2) == 0),
             ($urandom_range(0, 4) == 0),
             re, ms);
      step("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
